// File: rtl/key_gesture_decoder.sv
// Key gesture decoder: per-key debounce followed by a small FSM that turns
// each debounced press into one tap/long-press event on a valid/ready port.
//
// Event handshake: evt_valid is raised in EMIT and stays high with evt_key and
// evt_long frozen until a rising clk edge sees evt_valid & evt_ready; that edge
// completes the transfer and evt_valid drops right after it. evt_ready is
// ignored whenever evt_valid is low.
module key_gesture_decoder #(
  parameter int NUM_KEYS   = 3,
  parameter int KEY_W      = 2,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4,
  parameter int TAP_MAX    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] inputkeys,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_long,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_REARM = 2'd3;

  // Stability counter reaches this value on the last cycle before accepting.
  localparam logic [7:0]       STAB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUR_MAX   = '1;

  logic [NUM_KEYS-1:0] deb;
  logic [7:0]          stab [NUM_KEYS];
  logic [1:0]          state;
  logic [CNT_W-1:0]    dur;
  logic [KEY_W-1:0]    first_key;
  logic                key_held;
  logic                is_long;

  // Per-key debounce: a level change is accepted only after it has been
  // seen for DEB_CYCLES consecutive cycles; any return to the accepted
  // level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        stab[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (inputkeys[i] != deb[i]) begin
          if (stab[i] == STAB_LAST) begin
            deb[i]  <= inputkeys[i];
            stab[i] <= '0;
          end else begin
            stab[i] <= stab[i] + 8'd1;
          end
        end else begin
          stab[i] <= '0;
        end
      end
    end
  end

  // Lowest-index debounced key that is currently down (priority encoder).
  always_comb begin
    first_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (deb[i]) begin
        first_key = KEY_W'(i);
      end
    end
  end

  // Debounced level of the captured key; a loop avoids indexing past
  // NUM_KEYS when KEY_W can encode more keys than exist.
  always_comb begin
    key_held = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_W'(i) == evt_key) begin
        key_held = deb[i];
      end
    end
  end

  // Widened compare so TAP_MAX may exceed the counter range.
  assign is_long = (64'(dur) > 64'(TAP_MAX));

  // Gesture FSM: capture a press, time it, offer one event, then wait for
  // every key to be released before accepting a new press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      dur      <= '0;
      evt_key  <= '0;
      evt_long <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|deb) begin
            evt_key <= first_key;
            dur     <= '0;
            state   <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (key_held) begin
            if (dur != DUR_MAX) begin
              dur <= dur + CNT_W'(1);
            end
          end else begin
            evt_long <= is_long;
            state    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            state <= ST_REARM;
          end
        end
        ST_REARM: begin
          if (deb == '0) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign evt_valid = (state == ST_EMIT);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Bench for key_gesture_decoder with DEB_CYCLES=2, TAP_MAX=4, NUM_KEYS=3.
// A raw key held for H cycles (H >= 2) gives a duration count of H-1, so the
// long/short boundary is H=5 (count 4, short) versus H=6 (count 5, long).
module tb_key_gesture_decoder;

  localparam int NK  = 3;
  localparam int KW  = 2;
  localparam int TAP = 4;
  localparam int W   = KW + 1;

  logic          clk;
  logic          reset;
  logic [NK-1:0] inputkeys;
  logic          evt_ready;
  logic          evt_valid;
  logic [KW-1:0] evt_key;
  logic          evt_long;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [NK-1:0] inputkeys2;
  logic          evt_ready2;
  logic          evt_valid2;
  logic [KW-1:0] evt_key2;
  logic          evt_long2;
  logic          busy2;
  logic [1:0]    dbg_state2;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;
  int evt_cnt;

  key_gesture_decoder #(
    .NUM_KEYS(NK), .KEY_W(KW), .CNT_W(16), .DEB_CYCLES(2), .TAP_MAX(TAP)
  ) dut (
    .clk(clk), .reset(reset), .inputkeys(inputkeys),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_long(evt_long), .busy(busy), .dbg_state(dbg_state)
  );

  key_gesture_decoder #(
    .NUM_KEYS(NK), .KEY_W(KW), .CNT_W(3), .DEB_CYCLES(2), .TAP_MAX(TAP)
  ) dut_narrow (
    .clk(clk), .reset(reset), .inputkeys(inputkeys2),
    .evt_valid(evt_valid2), .evt_ready(evt_ready2), .evt_key(evt_key2),
    .evt_long(evt_long2), .busy(busy2), .dbg_state(dbg_state2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NK-1:0] mask, input int hold);
    inputkeys = mask;
    tick(hold);
    inputkeys = '0;
  endtask

  task automatic push_exp(input int key, input int hold);
    logic [KW-1:0] k;
    k = KW'(key);
    exp_q.push_back({k, ((hold - 1) > TAP)});
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake pops one expected {key, long}.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      evt_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", exp_q.size(), 1);
      end else begin
        chk("evt", {evt_key, evt_long}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int cnt0;
    int k;
    int h;
    logic seen;
    logic [KW-1:0] sk;
    logic sl;

    total = 0;
    bad = 0;
    evt_cnt = 0;
    reset = 1'b0;
    inputkeys = '0;
    inputkeys2 = '0;
    evt_ready = 1'b0;
    evt_ready2 = 1'b1;
    #1;
    tick(2);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key", evt_key, 2'd0);
    chk("rst_long", evt_long, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_busy2", busy2, 1'b0);
    reset = 1'b1;
    tick(1);

    // Single short tap on key 0
    evt_ready = 1'b1;
    cnt0 = evt_cnt;
    push_exp(0, 3);
    press(3'b001, 3);
    wait_done("done_tap");
    chk("tap_count", evt_cnt - cnt0, 1);

    // Key 1: long hold and the short/long boundary
    push_exp(1, 10);
    press(3'b010, 10);
    wait_done("done_long");
    push_exp(1, 5);
    press(3'b010, 5);
    wait_done("done_cnt4");
    push_exp(1, 6);
    press(3'b010, 6);
    wait_done("done_cnt5");

    // One-cycle glitches on key 2 must be filtered
    cnt0 = evt_cnt;
    for (int i = 0; i < 4; i++) begin
      inputkeys = 3'b100;
      tick(1);
      chk("glitch_busy_a", busy, 1'b0);
      inputkeys = '0;
      tick(2);
      chk("glitch_busy_b", busy, 1'b0);
    end
    chk("glitch_count", evt_cnt - cnt0, 0);

    // Keys 0 and 2 together, consumer stalls for 5 cycles
    evt_ready = 1'b0;
    push_exp(0, 4);
    inputkeys = 3'b101;
    tick(4);
    inputkeys = 3'b100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_seen", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", evt_valid, 1'b1);
      chk("stall_key", evt_key, 2'd0);
      chk("stall_long", evt_long, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cnt0 = evt_cnt;
    evt_ready = 1'b1;
    tick(10);
    chk("stall_count", evt_cnt - cnt0, 1);
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_state", dbg_state, 2'd3);
    chk("rearm_valid", evt_valid, 1'b0);
    inputkeys = '0;
    tick(4);
    chk("rearm_exit", busy, 1'b0);
    push_exp(2, 3);
    press(3'b100, 3);
    wait_done("done_repress");

    // Reset in the middle of a press on key 0
    cnt0 = evt_cnt;
    inputkeys = 3'b001;
    tick(4);
    chk("mid_state", dbg_state, 2'd1);
    reset = 1'b0;
    tick(1);
    chk("mrst_valid", evt_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_key", evt_key, 2'd0);
    chk("mrst_long", evt_long, 1'b0);
    reset = 1'b1;
    push_exp(0, 3);
    tick(3);
    inputkeys = '0;
    wait_done("done_mrst");
    chk("mrst_count", evt_cnt - cnt0, 1);

    // Random single-key presses
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, NK - 1);
      h = $urandom_range(2, 9);
      push_exp(k, h);
      press(3'(1 << k), h);
      wait_done("done_rand");
    end

    // Narrow counter: a 20-cycle hold saturates instead of wrapping
    inputkeys2 = 3'b010;
    tick(20);
    inputkeys2 = '0;
    seen = 1'b0;
    sk = '0;
    sl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (evt_valid2) begin
        seen = 1'b1;
        sk = evt_key2;
        sl = evt_long2;
        break;
      end
    end
    chk("sat_seen", seen, 1'b1);
    chk("sat_key", sk, 2'd1);
    chk("sat_long", sl, 1'b1);
    tick(6);
    chk("sat_idle", busy2, 1'b0);

    // Narrow counter: count 4 still short
    inputkeys2 = 3'b001;
    tick(5);
    inputkeys2 = '0;
    seen = 1'b0;
    sl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (evt_valid2) begin
        seen = 1'b1;
        sl = evt_long2;
        break;
      end
    end
    chk("narrow_seen", seen, 1'b1);
    chk("narrow_short", sl, 1'b0);

    tick(4);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_gesture_decoder.md
KEY_GESTURE_DECODER -- requirements
Module: key_gesture_decoder

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 3, giving the number of key inputs (range 2..16).
REQ-002 The block SHALL have parameter KEY_W, default 2, giving the width of the key index and equal to ceil(log2(NUM_KEYS)).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the press-duration counter.
REQ-004 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable cycles required to accept a key level change (range 1..255).
REQ-005 The block SHALL have parameter TAP_MAX, default 4, giving the maximum press count classified as a short press.
REQ-006 The block SHALL have port clk, input, width 1, as the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, width 1, as the synchronous active-low reset: 0 sampled at a rising clk edge resets the block.
REQ-008 The block SHALL have port inputkeys, input, width NUM_KEYS, carrying raw key levels (1 = pressed).
REQ-009 The block SHALL have port evt_valid, output, width 1, asserted while an event is offered.
REQ-010 The block SHALL have port evt_ready, input, width 1, asserted when the consumer accepts an event.
REQ-011 The block SHALL have port evt_key, output, width KEY_W, carrying the index of the key that produced the event.
REQ-012 The block SHALL have port evt_long, output, width 1, set to 1 for a long press and 0 for a short press.
REQ-013 The block SHALL have port busy, output, width 1, equal to 1 whenever the FSM is not in IDLE.

Function
REQ-014 Debounce SHALL be per key with a stability counter: raw != deb -> counter increments; raw == deb -> counter cleared; raw != deb with counter == DEB_CYCLES-1 -> deb <= raw and counter cleared.
REQ-015 A raw change held for DEB_CYCLES consecutive cycles SHALL be visible on deb after the DEB_CYCLES-th edge; shorter glitches SHALL leave deb unchanged.
REQ-016 The FSM SHALL have states IDLE, PRESS, EMIT and REARM; all decisions use debounced levels only.
REQ-017 In IDLE with any deb bit high, the FSM SHALL capture the lowest-index high key into evt_key, clear the duration counter, and enter PRESS.
REQ-018 In PRESS, each cycle with the captured key deb high SHALL increment the duration counter, saturating at 2^CNT_W-1 without wrap-around.
REQ-019 In PRESS, the first cycle with the captured key deb low SHALL set evt_long = (counter > TAP_MAX) and enter EMIT; that cycle does not increment the counter.
REQ-020 In PRESS, keys other than the captured key SHALL be ignored.
REQ-021 In EMIT, evt_valid SHALL be 1 and evt_key/evt_long SHALL be held stable until a cycle with evt_valid & evt_ready; on that edge the FSM SHALL enter REARM.
REQ-022 evt_valid SHALL never deassert without a handshake; evt_ready while not in EMIT SHALL have no effect.
REQ-023 In REARM, the FSM SHALL return to IDLE on the first cycle in which all deb bits are low, so each physical press yields exactly one event and keys held across an event are discarded.
REQ-024 evt_valid SHALL be 0 in IDLE, PRESS and REARM; evt_key and evt_long retain their last values outside EMIT.
REQ-025 Latency SHALL be: release debounced -> evt_valid high on the next cycle; handshake edge -> evt_valid low on the same edge.

Reset
REQ-026 On reset==0 at a rising edge, the FSM SHALL enter IDLE, and all deb bits, stability counters, the duration counter, evt_valid, evt_key, evt_long and busy SHALL become 0, regardless of state.
REQ-027 Reset mid-press or mid-EMIT SHALL discard the pending event; a key still held after reset SHALL be treated as a new press once debounced.

Verification (DEB_CYCLES=2, TAP_MAX=4, NUM_KEYS=3)
REQ-028 The bench SHALL drive inputkeys=001 for 3 deb-high cycles then 000 with evt_ready=1 -> exactly one event with evt_key=0, evt_long=0.
REQ-029 The bench SHALL hold key 1 deb-high for 10 cycles then release -> evt_key=1, evt_long=1; the bench SHALL check the boundary at counts 4 (short) and 5 (long).
REQ-030 The bench SHALL drive 1-cycle raw pulses on key 2 -> no deb change, busy stays 0, no event.
REQ-031 The bench SHALL press keys 0 and 2 simultaneously, release 0, and hold evt_ready=0 for 5 cycles -> evt_valid and evt_key=0 stable for 5 cycles, key 2 produces no event until all keys are released and re-pressed.
REQ-032 The bench SHALL assert reset=0 during PRESS with key 0 held -> all outputs 0 next cycle; after reset=1, the continued hold and release yield one event with evt_key=0.
REQ-033 The bench SHALL build with CNT_W=3 and hold a key for 20 cycles -> the counter saturates at 7, yields evt_long=1, and does not wrap.
